log_arbiter: RTL and testbench

LOG_ARBITER -- requirements
Module: log_arbiter

---
 rtl/log_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_log_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_arbiter.sv
// log_arbiter: two-port round-robin front end for a shared handshake logic unit.
// One transaction runs at a time: grant, one-cycle chip-select, wait for the
// unit to go busy and then ready, capture the result, and pulse done. A cycle
// counter covers both wait states and aborts with err if the unit never answers.
// Every output comes straight from a flop.
module log_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req0,
  input  logic [1:0]  op0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  output logic        done0,
  output logic        err0,
  output logic [15:0] res0,
  // requester 1
  input  logic        req1,
  input  logic [1:0]  op1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        done1,
  output logic        err1,
  output logic [15:0] res1,
  // logic unit
  output logic        lu_cs,
  output logic [1:0]  lu_op,
  output logic [15:0] lu_a,
  output logic [15:0] lu_b,
  input  logic        lu_rdy,
  input  logic [15:0] lu_out
);

  // Counter wide enough to hold the value TIMEOUT itself.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;

  // Granted port of the current transaction and port granted last time.
  logic          gnt_q,   gnt_d;
  logic          last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Registered outputs.
  logic          lu_cs_q, lu_cs_d;
  logic [1:0]    lu_op_q, lu_op_d;
  logic [15:0]   lu_a_q,  lu_a_d;
  logic [15:0]   lu_b_q,  lu_b_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err0_q,  err0_d;
  logic          err1_q,  err1_d;
  logic [15:0]   res0_q,  res0_d;
  logic [15:0]   res1_q,  res1_d;

  // Shared decode used by both the next-state and the output logic.
  logic          any_req;
  logic          grant_sel;
  logic          in_wait;
  logic [CW-1:0] cnt_inc;
  logic          tmo_hit;
  logic          capture;

  // Round-robin pick, timeout detect and result-capture qualifier.
  always_comb begin
    any_req   = req0 | req1;
    // On a tie the port not granted last wins; a lone request always wins.
    grant_sel = (req0 & req1) ? ~last_q : req1;
    in_wait   = (state_q == WAIT_LO) || (state_q == WAIT_HI);
    cnt_inc   = cnt_q + 1'b1;
    // The abort takes priority so a transaction never outlives its budget.
    tmo_hit   = in_wait && (cnt_inc == TIMEOUT_C);
    capture   = (state_q == WAIT_HI) && lu_rdy && !tmo_hit;
  end

  // State register and all output/datapath flops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      lu_cs_q <= 1'b0;
      lu_op_q <= 2'd0;
      lu_a_q  <= 16'h0000;
      lu_b_q  <= 16'h0000;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      res0_q  <= 16'h0000;
      res1_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lu_cs_q <= lu_cs_d;
      lu_op_q <= lu_op_d;
      lu_a_q  <= lu_a_d;
      lu_b_q  <= lu_b_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  // Next-state logic of the transaction FSM.
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT_LO;
      WAIT_LO: begin
        if (tmo_hit)      state_d = DONE;
        else if (!lu_rdy) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tmo_hit || capture) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless a state acts on it.
  always_comb begin
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    lu_cs_d = 1'b0;
    lu_op_d = lu_op_q;
    lu_a_d  = lu_a_q;
    lu_b_d  = lu_b_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    res0_d  = res0_q;
    res1_d  = res1_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          // Operands are latched once here and frozen until DONE is left.
          gnt_d   = grant_sel;
          last_d  = grant_sel;
          lu_cs_d = 1'b1;
          if (grant_sel) begin
            lu_op_d = op1;
            lu_a_d  = a1;
            lu_b_d  = b1;
          end else begin
            lu_op_d = op0;
            lu_a_d  = a0;
            lu_b_d  = b0;
          end
        end
      end
      WAIT_LO, WAIT_HI: begin
        cnt_d = cnt_inc;
        if (tmo_hit || capture) begin
          // Only the granted port's done/err/res move.
          if (gnt_q) begin
            done1_d = 1'b1;
            err1_d  = tmo_hit;
            if (capture) res1_d = lu_out;
          end else begin
            done0_d = 1'b1;
            err0_d  = tmo_hit;
            if (capture) res0_d = lu_out;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign lu_cs = lu_cs_q;
  assign lu_op = lu_op_q;
  assign lu_a  = lu_a_q;
  assign lu_b  = lu_b_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign err0  = err0_q;
  assign err1  = err1_q;
  assign res0  = res0_q;
  assign res1  = res1_q;

`ifndef SYNTHESIS
  // Chip-select is high exactly while the FSM sits in ISSUE.
  a_cs_issue: assert property (@(posedge clk) disable iff (!rst_n)
    lu_cs_q == (state_q == ISSUE));
  // Done pulses belong to a single port and only in DONE.
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(done0_q && done1_q));
  a_done_state: assert property (@(posedge clk) disable iff (!rst_n)
    (done0_q || done1_q) |-> (state_q == DONE));
  // An error is always reported together with its done.
  a_err0_done: assert property (@(posedge clk) disable iff (!rst_n)
    err0_q |-> done0_q);
  a_err1_done: assert property (@(posedge clk) disable iff (!rst_n)
    err1_q |-> done1_q);
`endif

endmodule

// File: tb/tb_log_arbiter.sv
// Bench for log_arbiter: a behavioural logic unit, a transaction-level model
// that predicts every output cycle by cycle, one compare process, and directed
// scenarios with hand-computed literal expectations.
module tb_log_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  op0 = 2'd0, op1 = 2'd0;
  logic [15:0] a0 = 16'h0, b0 = 16'h0, a1 = 16'h0, b1 = 16'h0;
  logic        done0, done1, err0, err1;
  logic [15:0] res0, res1;
  logic        lu_cs;
  logic [1:0]  lu_op;
  logic [15:0] lu_a, lu_b;
  logic        lu_rdy = 1'b1;
  logic [15:0] lu_out = 'z;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;
  logic lu_stuck = 1'b0;

  log_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .done0(done0), .err0(err0), .res0(res0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .done1(done1), .err1(err1), .res1(res1),
    .lu_cs(lu_cs), .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b),
    .lu_rdy(lu_rdy), .lu_out(lu_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] logic_fn(input logic [1:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      2'd0:    return ~(a & b);
      2'd1:    return ~(a | b);
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Logic unit: goes busy the cycle after it sees cs, stays busy one cycle,
  // then raises ready with the result for one cycle. When stuck it ignores cs.
  logic [15:0] lu_res = 16'h0;
  int          lu_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      lu_rdy = 1'b1;
      lu_out = 'z;
      lu_cnt = 0;
    end else if (lu_cnt == 0) begin
      lu_out = 'z;
      if (lu_cs && !lu_stuck) begin
        lu_rdy = 1'b0;
        lu_res = logic_fn(lu_op, lu_a, lu_b);
        lu_cnt = 1;
      end else begin
        lu_rdy = 1'b1;
      end
    end else if (lu_cnt == 1) begin
      lu_cnt = 2;
    end else begin
      lu_rdy = 1'b1;
      lu_out = lu_res;
      lu_cnt = 0;
    end
  end

  // Transaction-level model: tracks the age of the current transaction in
  // edges since its grant. Completion is 3 edges after grant with a compliant
  // unit, or TO+1 edges (TO cycles of waiting) when the unit never answers.
  // One further edge returns to idle before a new grant may happen.
  logic        m_busy, m_port, m_last, m_stuck;
  int          m_age, m_fin;
  logic        e_cs, e_done0, e_done1, e_err0, e_err1;
  logic [1:0]  e_op;
  logic [15:0] e_a, e_b, e_res0, e_res1;

  task automatic model_reset();
    m_busy = 1'b0; m_port = 1'b0; m_last = 1'b1; m_stuck = 1'b0;
    m_age = 0; m_fin = 0;
    e_cs = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
    e_op = 2'd0; e_a = 16'h0; e_b = 16'h0; e_res0 = 16'h0; e_res1 = 16'h0;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      e_cs = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      if (m_busy) begin
        m_age++;
        if (m_age == m_fin) begin
          if (m_port) begin
            e_done1 = 1'b1;
            e_err1  = m_stuck;
            if (!m_stuck) e_res1 = logic_fn(e_op, e_a, e_b);
          end else begin
            e_done0 = 1'b1;
            e_err0  = m_stuck;
            if (!m_stuck) e_res0 = logic_fn(e_op, e_a, e_b);
          end
        end else if (m_age > m_fin) begin
          m_busy = 1'b0;
        end
      end else if (req0 || req1) begin
        m_port  = (req0 && req1) ? ~m_last : req1;
        m_last  = m_port;
        m_busy  = 1'b1;
        m_age   = 0;
        m_stuck = lu_stuck;
        m_fin   = lu_stuck ? int'(TO) + 1 : 3;
        e_cs    = 1'b1;
        e_op    = m_port ? op1 : op0;
        e_a     = m_port ? a1 : a0;
        e_b     = m_port ? b1 : b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("lu_cs", {15'd0, lu_cs}, {15'd0, e_cs});
      check("lu_op", {14'd0, lu_op}, {14'd0, e_op});
      check("lu_a",  lu_a, e_a);
      check("lu_b",  lu_b, e_b);
      check("done0", {15'd0, done0}, {15'd0, e_done0});
      check("done1", {15'd0, done1}, {15'd0, e_done1});
      check("err0",  {15'd0, err0},  {15'd0, e_err0});
      check("err1",  {15'd0, err1},  {15'd0, e_err1});
      check("res0",  res0, e_res0);
      check("res1",  res1, e_res1);
    end
  end

  // Wait for a done pulse on one port; counts chip-select cycles seen meanwhile.
  task automatic wait_done(input int port, output int cs_seen);
    cs_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (lu_cs) cs_seen++;
      if ((port == 0) ? done0 : done1) return;
    end
    errors++;
    $display("FAIL wait_done%0d actual=no_done expected=done within 60 cycles", port);
  endtask

  // Wait for a done pulse on either port and report which one.
  task automatic wait_any(output int port);
    port = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) begin
        port = done1 ? 1 : 0;
        return;
      end
    end
    errors++;
    $display("FAIL wait_any actual=no_done expected=done within 60 cycles");
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cs_n;
    int port;
    int order [4];
    int k_cs, k_done;
    logic saw_err;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    check("rst_res0", res0, 16'h0000);
    check("rst_lu_a", lu_a, 16'h0000);
    check("rst_cs",   {15'd0, lu_cs}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: NAND.
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd0; a0 = 16'hFF00; b0 = 16'h0F0F;
    wait_done(0, cs_n);
    check("t1_res0",       res0, 16'hF0FF);
    check("t1_model_res0", e_res0, 16'hF0FF);
    check("t1_err0",       {15'd0, err0}, 16'h0000);
    check("t1_cs_pulses",  16'(cs_n), 16'd1);
    @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    // Tie after reset: port 0 first, then alternation.
    do_reset(2);
    req0 = 1'b1; op0 = 2'd2; a0 = 16'hAAAA; b0 = 16'h5555;
    req1 = 1'b1; op1 = 2'd3; a1 = 16'h1234; b1 = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      wait_any(port);
      order[i] = port;
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    check("t2_order0", 16'(order[0]), 16'd0);
    check("t2_order1", 16'(order[1]), 16'd1);
    check("t2_order2", 16'(order[2]), 16'd0);
    check("t2_order3", 16'(order[3]), 16'd1);
    check("t2_res0",       res0, 16'hFFFF);
    check("t2_res1",       res1, 16'hEDCB);
    check("t2_model_res1", e_res1, 16'hEDCB);
    repeat (2) @(negedge clk);

    // Timeout: the unit never goes busy.
    lu_stuck = 1'b1;
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd1; a0 = 16'h1111; b0 = 16'h2222;
    k_cs = -1; k_done = -1; saw_err = 1'b0;
    for (int i = 0; i < 40 && k_done < 0; i++) begin
      @(posedge clk); #1;
      if (lu_cs) k_cs = i;
      if (done0) begin
        k_done  = i;
        saw_err = err0;
      end
    end
    @(negedge clk);
    req0 = 1'b0;
    check("t3_done_seen", {15'd0, (k_done >= 0)}, 16'd1);
    check("t3_err0",      {15'd0, saw_err}, 16'd1);
    check("t3_latency",   16'(k_done - k_cs), 16'(TO + 1));
    check("t3_res0_held", res0, 16'hFFFF);
    repeat (2) @(negedge clk);
    lu_stuck = 1'b0;
    @(negedge clk);

    // Operand change and request drop right after the grant.
    req0 = 1'b1; op0 = 2'd2; a0 = 16'h00FF; b0 = 16'h0F0F;
    @(posedge clk); #1;
    check("t4_cs",       {15'd0, lu_cs}, 16'd1);
    check("t4_lu_a_gnt", lu_a, 16'h00FF);
    @(negedge clk);
    a0 = 16'hFFFF; req0 = 1'b0;
    wait_done(0, cs_n);
    check("t4_res0",  res0, 16'h0FF0);
    check("t4_lu_a",  lu_a, 16'h00FF);
    repeat (3) @(negedge clk);

    // Reset while in WAIT_HI, then a fresh transaction on port 1.
    req1 = 1'b1; op1 = 2'd1; a1 = 16'h0000; b1 = 16'h00FF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t5_done1_rst", {15'd0, done1}, 16'd0);
      check("t5_res0_rst",  res0, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req1 = 1'b1;
    wait_done(1, cs_n);
    check("t5_res1", res1, 16'hFF00);
    check("t5_err1", {15'd0, err1}, 16'd0);
    @(negedge clk);
    req1 = 1'b0;
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
